// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, producer side of the IF/ID register.
// Owns the PC, runs a single-outstanding request/acknowledge instruction bus,
// and presents {valid, pc, raw_instr} downstream. Handles downstream stall and
// redirects, including dropping a response that belongs to a stale address.
// Optional build macro: FETCH_PERF_EN adds stall-cycle and discard counters.
module fetch_unit #(
   parameter int XLEN = 64,
   parameter logic [XLEN-1:0] PC_RESET = XLEN'(64'h0000_0000_8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            ireq_valid,
   output logic [XLEN-1:0] ireq_addr,
   input  logic            iresp_data_ok,
   input  logic [31:0]     iresp_data,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0]     fetch_raw_instr,
   output logic [31:0]     perf_stall_cycles,
   output logic [31:0]     perf_discards
`else
   output logic [31:0]     fetch_raw_instr
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pending_pc_q, pending_pc_d;
   logic [XLEN-1:0] buf_pc_q, buf_pc_d;
   logic [31:0]     buf_instr_q, buf_instr_d;

   // Next-state and PC/buffer update for the fetch controller
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      buf_pc_d     = buf_pc_q;
      buf_instr_d  = buf_instr_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (iresp_data_ok) begin
               if (redirect_valid) begin
                  pc_d = redirect_pc;
               end else if (!stall) begin
                  pc_d = pc_q + XLEN'(4);
               end else begin
                  buf_pc_d    = pc_q;
                  buf_instr_d = iresp_data;
                  state_d     = ST_HOLD;
               end
            end else if (redirect_valid) begin
               // Request already on the bus must complete at its old address
               pending_pc_d = redirect_pc;
               state_d      = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (iresp_data_ok) begin
               pc_d    = redirect_valid ? redirect_pc : pending_pc_q;
               state_d = ST_REQ;
            end else if (redirect_valid) begin
               pending_pc_d = redirect_pc;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d        = redirect_pc;
               buf_pc_d    = '0;
               buf_instr_d = '0;
               state_d     = ST_REQ;
            end else if (!stall) begin
               pc_d    = buf_pc_q + XLEN'(4);
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus request and IF/ID payload outputs, decoded from the current state
   always_comb begin
      ireq_valid      = 1'b0;
      ireq_addr       = '0;
      fetch_valid     = 1'b0;
      fetch_pc        = '0;
      fetch_raw_instr = '0;
      case (state_q)
         ST_REQ: begin
            ireq_valid  = 1'b1;
            ireq_addr   = pc_q;
            fetch_valid = iresp_data_ok & ~redirect_valid;
            if (iresp_data_ok) begin
               fetch_pc        = pc_q;
               fetch_raw_instr = iresp_data;
            end
         end
         ST_DISCARD: begin
            ireq_valid = 1'b1;
            ireq_addr  = pc_q;
         end
         ST_HOLD: begin
            fetch_valid     = ~redirect_valid;
            fetch_pc        = buf_pc_q;
            fetch_raw_instr = buf_instr_q;
         end
         default: begin
         end
      endcase
   end

   // Controller state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= PC_RESET;
         pending_pc_q <= '0;
         buf_pc_q     <= '0;
         buf_instr_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         buf_pc_q     <= buf_pc_d;
         buf_instr_q  <= buf_instr_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_disc_q, perf_disc_d;

   // Count stalled HOLD cycles and every response that is thrown away
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_disc_d  = perf_disc_q;
      if (state_q == ST_HOLD && stall) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if ((state_q == ST_REQ && iresp_data_ok && redirect_valid) ||
          (state_q == ST_DISCARD && iresp_data_ok)) begin
         perf_disc_d = perf_disc_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_disc_q  <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_disc_q  <= perf_disc_d;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_discards     = perf_disc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs change 1 time unit after each rising edge; outputs are sampled one
// further unit later, so every check sees settled combinational values.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        fetch_valid;
   logic [63:0] fetch_pc;
   logic [31:0] fetch_raw_instr;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_discards;
`endif

   int errors = 0;
   int checks = 0;

   fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .ireq_valid      (ireq_valid),
      .ireq_addr       (ireq_addr),
      .iresp_data_ok   (iresp_data_ok),
      .iresp_data      (iresp_data),
      .fetch_valid     (fetch_valid),
      .fetch_pc        (fetch_pc),
`ifdef FETCH_PERF_EN
      .fetch_raw_instr (fetch_raw_instr),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_discards   (perf_discards)
`else
      .fetch_raw_instr (fetch_raw_instr)
`endif
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the bus/control inputs, then let combinational outputs settle
   task automatic applyStimulus(input logic s, input logic rv, input logic [63:0] rpc,
                                input logic ok, input logic [31:0] data);
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rpc;
      iresp_data_ok  = ok;
      iresp_data     = data;
      #1;
   endtask

   // One comparison of an observed output against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check the complete output bundle in one go
   task automatic checkAll(input string tag, input logic rv, input logic [63:0] ra,
                           input logic fv, input logic [63:0] fp, input logic [31:0] fi);
      checkOutput({tag, ".ireq_valid"}, 64'(ireq_valid), 64'(rv));
      checkOutput({tag, ".ireq_addr"}, ireq_addr, ra);
      checkOutput({tag, ".fetch_valid"}, 64'(fetch_valid), 64'(fv));
      checkOutput({tag, ".fetch_pc"}, fetch_pc, fp);
      checkOutput({tag, ".fetch_raw"}, 64'(fetch_raw_instr), 64'(fi));
   endtask

   localparam logic [31:0] NOP = 32'hD503201F;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      tick();
      tick();
      checkAll("reset", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);

      // Release reset: one IDLE cycle, then a zero-wait stream of fetches
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, NOP);
      checkAll("idle", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, NOP);
      checkAll("stream0", 1'b1, 64'h8000_0000, 1'b1, 64'h8000_0000, NOP);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, NOP);
      checkAll("stream1", 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0004, NOP);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, NOP);
      checkAll("stream2", 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0008, NOP);

      // Outstanding request at ...0C, then asynchronous reset mid-cycle
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      checkAll("outstanding", 1'b1, 64'h8000_000C, 1'b0, 64'h0, 32'h0);
      rst = 1'b1;
      #1;
      checkAll("async_rst", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF);
      checkAll("late_ok_idle", 1'b0, 64'h0, 1'b0, 64'h0, 32'h0);

      // First request after reset is accepted while downstream stalls
      tick();
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h1111_2222);
      checkAll("req_stall", 1'b1, 64'h8000_0000, 1'b1, 64'h8000_0000, 32'h1111_2222);
      tick();
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h5555_5555);
      checkAll("hold0", 1'b0, 64'h0, 1'b1, 64'h8000_0000, 32'h1111_2222);
      tick();
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h6666_6666);
      checkAll("hold1", 1'b0, 64'h0, 1'b1, 64'h8000_0000, 32'h1111_2222);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      checkAll("hold2", 1'b0, 64'h0, 1'b1, 64'h8000_0000, 32'h1111_2222);

      // Redirect with a request outstanding: address held until data_ok
      tick();
      applyStimulus(1'b0, 1'b1, 64'h8000_1000, 1'b0, 32'h0);
      checkAll("redir_req", 1'b1, 64'h8000_0004, 1'b0, 64'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      checkAll("discard0", 1'b1, 64'h8000_0004, 1'b0, 64'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h7777_7777);
      checkAll("discard_ok", 1'b1, 64'h8000_0004, 1'b0, 64'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h3333_4444);
      checkAll("after_discard", 1'b1, 64'h8000_1000, 1'b1, 64'h8000_1000, 32'h3333_4444);

      // Redirect while holding a stalled word: redirect beats stall
      tick();
      applyStimulus(1'b1, 1'b1, 64'h8000_2000, 1'b0, 32'h0);
      checkOutput("hold_redir.fetch_valid", 64'(fetch_valid), 64'h0);
      checkOutput("hold_redir.ireq_valid", 64'(ireq_valid), 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      checkAll("post_hold_redir", 1'b1, 64'h8000_2000, 1'b0, 64'h0, 32'h0);

      // Response with redirect in REQ is dropped; then PC wraps past the top
      applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h8888_8888);
      checkAll("redir_drop", 1'b1, 64'h8000_2000, 1'b0, 64'h8000_2000, 32'h8888_8888);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, NOP);
      checkAll("top_pc", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, NOP);
      tick();
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      checkAll("wrap", 1'b1, 64'h0, 1'b0, 64'h0, 32'h0);

`ifdef FETCH_PERF_EN
      checkOutput("perf_stall_cycles", 64'(perf_stall_cycles), 64'd3);
      checkOutput("perf_discards", 64'(perf_discards), 64'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
